fwd_hazard_ctrl: RTL and testbench

//  Parametrised forwarding and load-use hazard controller for the 5-stage core, with NSRC source operands.

---
 rtl/fwd_hazard_ctrl.sv | 146 ++++++++++++++
 tb/tb_fwd_hazard_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fwd_hazard_ctrl
// Description : Forwarding and load-use hazard controller for the 5-stage
//               core. Generates ID write-through and EX bypass selects,
//               sequences load-use stalls, and holds WB results that retire
//               while the pipeline is frozen.
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_hazard_ctrl #(
    parameter int NSRC      = 2,
    parameter int RA_W      = 5,
    parameter int DATA_W    = 32,
    parameter int LU_CYCLES = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [NSRC*RA_W-1:0]     id_rs,
    input  logic [NSRC*RA_W-1:0]     ex_rs,
    input  logic                     mem_we,
    input  logic [RA_W-1:0]          mem_rd,
    input  logic                     mem_is_load,
    input  logic                     wb_we,
    input  logic [RA_W-1:0]          wb_rd,
    input  logic [DATA_W-1:0]        wb_data,
    output logic [NSRC-1:0]          id_fwd,
    output logic [NSRC*2-1:0]        ex_sel,
    output logic [NSRC*DATA_W-1:0]   hold_data,
    output logic                     stall
);

    localparam int c_CNT_W = $clog2(LU_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_INIT = c_CNT_W'(LU_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_STALL = 1'b1
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [c_CNT_W-1:0]        r_cnt;
    logic [c_CNT_W-1:0]        w_cnt_nxt;
    logic [NSRC-1:0]           r_hold_vld;
    logic [NSRC*DATA_W-1:0]    r_hold_data;
    logic [NSRC-1:0]           w_mem_hit;
    logic [NSRC-1:0]           w_wb_hit;
    logic                      w_lu_det;
    logic                      w_stall;
    logic                      w_hold_clr;

    // Per-source hit detection and operand mux selects; x0 never forwards
    generate
        for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
            logic [RA_W-1:0] w_ex_rs;
            logic [RA_W-1:0] w_id_rs;

            assign w_ex_rs       = ex_rs[gi*RA_W +: RA_W];
            assign w_id_rs       = id_rs[gi*RA_W +: RA_W];
            assign w_mem_hit[gi] = mem_we && (w_ex_rs == mem_rd) && (w_ex_rs != '0);
            assign w_wb_hit[gi]  = wb_we  && (w_ex_rs == wb_rd)  && (w_ex_rs != '0);
            assign id_fwd[gi]    = wb_we  && (w_id_rs == wb_rd)  && (w_id_rs != '0);

            // Newest producer wins: MEM over WB over a held value
            assign ex_sel[gi*2 +: 2] = w_mem_hit[gi]  ? 2'd2 :
                                       w_wb_hit[gi]   ? 2'd1 :
                                       r_hold_vld[gi] ? 2'd3 : 2'd0;
        end
    endgenerate

    // A load in MEM feeding any EX source cannot be bypassed in time
    assign w_lu_det = mem_is_load && (|w_mem_hit);

    // State and counter registers of the load-use sequencer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state, counter and stall decode; the detection cycle itself is the
    // first stall cycle, so the counter starts at LU_CYCLES-1
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_stall     = 1'b0;
        w_hold_clr  = 1'b0;
        if (flush) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_hold_clr  = 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_stall = w_lu_det;
                    if (w_lu_det) begin
                        w_state_nxt = S_STALL;
                        w_cnt_nxt   = c_CNT_INIT;
                    end
                end
                S_STALL: begin
                    if (r_cnt != '0) begin
                        w_stall   = 1'b1;
                        w_cnt_nxt = r_cnt - c_CNT_ONE;
                    end else begin
                        // Release cycle: EX consumes any held operands
                        w_state_nxt = S_IDLE;
                        w_hold_clr  = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Capture WB results retiring under a frozen EX; later captures overwrite
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_vld  <= '0;
            r_hold_data <= '0;
        end else if (w_hold_clr) begin
            r_hold_vld <= '0;
        end else if (w_stall) begin
            for (int i = 0; i < NSRC; i++) begin
                if (w_wb_hit[i]) begin
                    r_hold_data[i*DATA_W +: DATA_W] <= wb_data;
                    r_hold_vld[i]                   <= 1'b1;
                end
            end
        end
    end

    assign hold_data = r_hold_data;
    assign stall     = w_stall;

endmodule
`default_nettype wire

// File: tb/tb_fwd_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fwd_hazard_ctrl
// Description : Self-checking bench for fwd_hazard_ctrl. Two instances
//               (LU_CYCLES=1 and 2) share stimulus; a sequence-length model
//               predicts every output each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fwd_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [9:0]  id_rs;
    logic [9:0]  ex_rs;
    logic        mem_we;
    logic [4:0]  mem_rd;
    logic        mem_is_load;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    logic [1:0]  id_fwd_o [2];
    logic [3:0]  ex_sel_o [2];
    logic [63:0] hold_o   [2];
    logic        stall_o  [2];

    int n_chk  = 0;
    int n_pass = 0;

    // Model: remaining length of the current stall sequence (stall cycles
    // still to come plus the release cycle), held flags and held data
    int          m_left [2];
    logic [1:0]  m_vld  [2];
    logic [31:0] m_data [2][2];

    always #5 clk = ~clk;

    fwd_hazard_ctrl #(.NSRC(2), .RA_W(5), .DATA_W(32), .LU_CYCLES(1)) u_dut_lu1 (
        .clk(clk), .rst(rst), .flush(flush), .id_rs(id_rs), .ex_rs(ex_rs),
        .mem_we(mem_we), .mem_rd(mem_rd), .mem_is_load(mem_is_load),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .id_fwd(id_fwd_o[0]), .ex_sel(ex_sel_o[0]), .hold_data(hold_o[0]),
        .stall(stall_o[0])
    );

    fwd_hazard_ctrl #(.NSRC(2), .RA_W(5), .DATA_W(32), .LU_CYCLES(2)) u_dut_lu2 (
        .clk(clk), .rst(rst), .flush(flush), .id_rs(id_rs), .ex_rs(ex_rs),
        .mem_we(mem_we), .mem_rd(mem_rd), .mem_is_load(mem_is_load),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .id_fwd(id_fwd_o[1]), .ex_sel(ex_sel_o[1]), .hold_data(hold_o[1]),
        .stall(stall_o[1])
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    function automatic logic hit(input logic we, input logic [4:0] rd, input logic [4:0] rs);
        return we && (rs == rd) && (rs != 5'd0);
    endfunction

    function automatic logic [4:0] ex_src(input int i);
        return (i == 0) ? ex_rs[4:0] : ex_rs[9:5];
    endfunction

    function automatic logic [4:0] id_src(input int i);
        return (i == 0) ? id_rs[4:0] : id_rs[9:5];
    endfunction

    function automatic logic lu_det();
        return mem_is_load && (hit(mem_we, mem_rd, ex_src(0)) || hit(mem_we, mem_rd, ex_src(1)));
    endfunction

    function automatic logic m_stall(input int k);
        if (flush)          return 1'b0;
        if (m_left[k] == 0) return lu_det();
        return m_left[k] > 1;
    endfunction

    function automatic logic [1:0] m_sel(input int k, input int i);
        if (hit(mem_we, mem_rd, ex_src(i))) return 2'd2;
        if (hit(wb_we, wb_rd, ex_src(i)))   return 2'd1;
        if (m_vld[k][i])                    return 2'd3;
        return 2'd0;
    endfunction

    task automatic check_model();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("m_stall[%0d]", k), stall_o[k], m_stall(k));
            chk($sformatf("m_ex_sel[%0d]", k), ex_sel_o[k], {m_sel(k, 1), m_sel(k, 0)});
            chk($sformatf("m_id_fwd[%0d]", k), id_fwd_o[k],
                {hit(wb_we, wb_rd, id_src(1)), hit(wb_we, wb_rd, id_src(0))});
            chk($sformatf("m_hold[%0d]", k), hold_o[k], {m_data[k][1], m_data[k][0]});
        end
    endtask

    // Advance the model by one clock using the inputs of the current cycle
    task automatic step();
        for (int k = 0; k < 2; k++) begin
            logic st;
            st = m_stall(k);
            if (rst) begin
                m_left[k] = 0;
                m_vld[k]  = 2'b00;
                m_data[k][0] = '0;
                m_data[k][1] = '0;
            end else begin
                if (flush) begin
                    m_left[k] = 0;
                    m_vld[k]  = 2'b00;
                end else if (m_left[k] == 0) begin
                    if (lu_det()) m_left[k] = k + 1;
                end else if (m_left[k] > 1) begin
                    m_left[k]--;
                end else begin
                    m_left[k] = 0;
                    m_vld[k]  = 2'b00;
                end
                if (st) begin
                    for (int i = 0; i < 2; i++) begin
                        if (hit(wb_we, wb_rd, ex_src(i))) begin
                            m_data[k][i] = wb_data;
                            m_vld[k][i]  = 1'b1;
                        end
                    end
                end
            end
        end
    endtask

    task automatic cyc(input logic r, input logic f, input logic [9:0] idr,
                       input logic [9:0] exr, input logic mwe, input logic [4:0] mrd,
                       input logic mld, input logic wwe, input logic [4:0] wrd,
                       input logic [31:0] wd);
        @(negedge clk);
        rst = r; flush = f; id_rs = idr; ex_rs = exr;
        mem_we = mwe; mem_rd = mrd; mem_is_load = mld;
        wb_we = wwe; wb_rd = wrd; wb_data = wd;
        #1;
        check_model();
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; id_rs = '0; ex_rs = '0;
        mem_we = 1'b0; mem_rd = '0; mem_is_load = 1'b0;
        wb_we = 1'b0; wb_rd = '0; wb_data = '0;
        for (int k = 0; k < 2; k++) begin
            m_left[k] = 0; m_vld[k] = 2'b00; m_data[k][0] = '0; m_data[k][1] = '0;
        end
        repeat (2) @(posedge clk);

        // Reset state with all inputs low
        cyc(0, 0, 10'd0, 10'd0, 0, 5'd0, 0, 0, 5'd0, 32'h0);
        for (int k = 0; k < 2; k++) begin
            chk("rst_stall", stall_o[k], 1'b0);
            chk("rst_ex_sel", ex_sel_o[k], 4'h0);
            chk("rst_id_fwd", id_fwd_o[k], 2'b00);
            chk("rst_hold", hold_o[k], 64'h0);
        end
        step();

        // ALU result in MEM, then in WB
        cyc(0, 0, 10'd0, {5'd0, 5'd5}, 1, 5'd5, 0, 0, 5'd0, 32'h0);
        chk("alu_mem_sel", ex_sel_o[0][1:0], 2'd2);
        chk("alu_mem_stall", stall_o[0], 1'b0);
        step();
        cyc(0, 0, 10'd0, {5'd0, 5'd5}, 0, 5'd0, 0, 1, 5'd5, 32'h55);
        chk("alu_wb_sel", ex_sel_o[0][1:0], 2'd1);
        step();

        // x0 is never forwarded
        cyc(0, 0, 10'd0, 10'd0, 1, 5'd0, 1, 1, 5'd0, 32'h1);
        for (int k = 0; k < 2; k++) begin
            chk("x0_ex_sel", ex_sel_o[k], 4'h0);
            chk("x0_id_fwd", id_fwd_o[k], 2'b00);
            chk("x0_stall", stall_o[k], 1'b0);
        end
        step();

        // Load x7 used by rs1; WB retires x9 for rs2 during the stall
        cyc(0, 0, {5'd7, 5'd0}, {5'd9, 5'd7}, 1, 5'd7, 1, 1, 5'd9, 32'hDEAD);
        chk("lu_stall_lu1", stall_o[0], 1'b1);
        chk("lu_stall_lu2", stall_o[1], 1'b1);
        chk("lu_sel_lu1", ex_sel_o[0], 4'b0110);
        step();
        cyc(0, 0, {5'd7, 5'd0}, {5'd9, 5'd7}, 0, 5'd0, 0, 1, 5'd7, 32'h77);
        chk("rel_stall_lu1", stall_o[0], 1'b0);
        chk("rel_sel_lu1", ex_sel_o[0], 4'b1101);
        chk("rel_hold1_lu1", hold_o[0][63:32], 32'hDEAD);
        chk("lu2_stall2", stall_o[1], 1'b1);
        chk("idfwd_in_stall", id_fwd_o[1], 2'b10);
        step();
        cyc(0, 0, 10'd0, {5'd9, 5'd7}, 0, 5'd0, 0, 0, 5'd0, 32'h0);
        chk("clr_sel_lu1", ex_sel_o[0], 4'h0);
        chk("rel_stall_lu2", stall_o[1], 1'b0);
        chk("rel_sel_lu2", ex_sel_o[1], 4'b1111);
        chk("rel_hold0_lu2", hold_o[1][31:0], 32'h77);
        step();
        cyc(0, 0, 10'd0, {5'd9, 5'd7}, 0, 5'd0, 0, 0, 5'd0, 32'h0);
        chk("clr_sel_lu2", ex_sel_o[1], 4'h0);
        step();

        // Write-through during a stall, then flush while LU2 is still stalling
        cyc(0, 0, {5'd3, 5'd0}, {5'd0, 5'd7}, 1, 5'd7, 1, 1, 5'd3, 32'h42);
        chk("wt_id_fwd", id_fwd_o[1], 2'b10);
        chk("wt_stall", stall_o[1], 1'b1);
        step();
        cyc(0, 1, 10'd0, {5'd0, 5'd7}, 0, 5'd0, 0, 1, 5'd7, 32'h99);
        chk("flush_stall", stall_o[1], 1'b0);
        step();
        cyc(0, 0, 10'd0, {5'd0, 5'd7}, 0, 5'd0, 0, 0, 5'd0, 32'h0);
        chk("post_flush_sel", ex_sel_o[1], 4'h0);
        chk("post_flush_stall", stall_o[1], 1'b0);
        step();

        // Reset in the middle of a stall
        cyc(0, 0, 10'd0, {5'd0, 5'd7}, 1, 5'd7, 1, 0, 5'd0, 32'h0);
        step();
        cyc(1, 0, 10'd0, {5'd0, 5'd7}, 0, 5'd0, 0, 1, 5'd7, 32'h11);
        step();
        cyc(0, 0, 10'd0, {5'd0, 5'd7}, 0, 5'd0, 0, 0, 5'd0, 32'h0);
        chk("post_rst_stall", stall_o[1], 1'b0);
        chk("post_rst_sel", ex_sel_o[1], 4'h0);
        chk("post_rst_hold", hold_o[1], 64'h0);
        step();

        // Randomised traffic over a small register window to provoke hits
        for (int n = 0; n < 600; n++) begin
            cyc(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0),
                {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))},
                {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))},
                1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                ($urandom_range(0, 2) == 0),
                1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
